// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if
//   Bundles the instruction-decode inputs and every datapath control output of
//   the multi-cycle control unit.
//   master : the control FSM (reads decode/status flags, drives controls)
//   slave  : the datapath (drives decode/status flags, reads controls)
//
//   Mult/div handshake: md_start is a single-cycle request pulse.
//   The unit has a fixed latency of MD_CYCLES cycles, so there is no return
//   "done" strobe.
//   md_div0 is sampled by the controller in the same cycle md_start is high.
//
//   Ports carried:
//     opcode[5:0], funct[5:0], of, eq, md_div0            datapath -> control
//     pc_w, mem_wr, ir_write, reg_write, ab_write,
//     alu_out_write, epc_write, md_start,
//     alu_src_a[1:0], alu_src_b[1:0], alu_op[2:0],
//     reg_dst[1:0], mem_to_reg[1:0], pc_source[1:0],
//     iord[1:0], exc_cause[1:0], state_dbg[4:0]            control -> datapath
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       of;
    logic       eq;
    logic       md_div0;

    logic       pc_w;
    logic       mem_wr;
    logic       ir_write;
    logic       reg_write;
    logic       ab_write;
    logic       alu_out_write;
    logic       epc_write;
    logic       md_start;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] iord;
    logic [1:0] exc_cause;
    logic [4:0] state_dbg;

    modport master (
        input  opcode, funct, of, eq, md_div0,
        output pc_w, mem_wr, ir_write, reg_write, ab_write, alu_out_write,
               epc_write, md_start, alu_src_a, alu_src_b, alu_op, reg_dst,
               mem_to_reg, pc_source, iord, exc_cause, state_dbg
    );

    modport slave (
        output opcode, funct, of, eq, md_div0,
        input  pc_w, mem_wr, ir_write, reg_write, ab_write, alu_out_write,
               epc_write, md_start, alu_src_a, alu_src_b, alu_op, reg_dst,
               mem_to_reg, pc_source, iord, exc_cause, state_dbg
    );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Multi-cycle MIPS-subset control unit.
//   - Memory reads take MEM_WAIT cycles.
//   - A fixed-latency mult/div unit runs for MD_CYCLES cycles.
//   - Precise exceptions (bad opcode/funct, overflow, divide by zero) capture
//     the EPC and fetch the handler address from a vector table.
//
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     reset : synchronous, active-high, overrides everything
//     bus   : mc_control_fsm_if.master (decode inputs + all control outputs)
module mc_control_fsm #(
    parameter int MEM_WAIT  = 1,
    parameter int MD_CYCLES = 32
) (
    input  logic               clk,
    input  logic               reset,
    mc_control_fsm_if.master   bus
);
    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,
        S_IR_LD    = 5'd1,
        S_DECODE   = 5'd2,
        S_EX_R     = 5'd3,
        S_WB_R     = 5'd4,
        S_EX_I     = 5'd5,
        S_WB_I     = 5'd6,
        S_ADDR     = 5'd7,
        S_MEM_RD   = 5'd8,
        S_WB_LD    = 5'd9,
        S_MEM_WR   = 5'd10,
        S_BR       = 5'd11,
        S_JMP      = 5'd12,
        S_MD_START = 5'd13,
        S_MD_WAIT  = 5'd14,
        S_EXC1     = 5'd15,
        S_EXC_RD   = 5'd16,
        S_EXC_LD   = 5'd17
    } state_t;

    localparam int MAX_WAIT = (MEM_WAIT > MD_CYCLES) ? MEM_WAIT : MD_CYCLES;
    localparam int CW       = $clog2(MAX_WAIT + 1);
    // Terminal counts: the counter starts at 0 on state entry, so a state held
    // N cycles leaves when the count reaches N-1.
    localparam logic [CW-1:0] MEM_LAST = CW'(MEM_WAIT - 1);
    localparam logic [CW-1:0] MD_LAST  = CW'(MD_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cause_q, cause_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic.
    // exc_cause is loaded only on entry to EXC1, so it holds its value until
    // the next exception.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH:  if (cnt_q == MEM_LAST) state_d = S_IR_LD;
            S_IR_LD:  state_d = S_DECODE;
            S_DECODE: begin
                if (bus.opcode == 6'h00 &&
                    (bus.funct == 6'h20 || bus.funct == 6'h22 || bus.funct == 6'h24))
                    state_d = S_EX_R;
                else if (bus.opcode == 6'h00 && (bus.funct == 6'h18 || bus.funct == 6'h1A))
                    state_d = S_MD_START;
                else if (bus.opcode == 6'h08)
                    state_d = S_EX_I;
                else if (bus.opcode == 6'h23 || bus.opcode == 6'h2B)
                    state_d = S_ADDR;
                else if (bus.opcode == 6'h04 || bus.opcode == 6'h05)
                    state_d = S_BR;
                else if (bus.opcode == 6'h02)
                    state_d = S_JMP;
                else begin
                    state_d = S_EXC1;
                    cause_d = 2'b00;
                end
            end
            S_EX_R: begin
                // and never overflows, so its of flag is ignored.
                if (bus.of && bus.funct != 6'h24) begin
                    state_d = S_EXC1;
                    cause_d = 2'b01;
                end else begin
                    state_d = S_WB_R;
                end
            end
            S_WB_R:   state_d = S_FETCH;
            S_EX_I: begin
                if (bus.of) begin
                    state_d = S_EXC1;
                    cause_d = 2'b01;
                end else begin
                    state_d = S_WB_I;
                end
            end
            S_WB_I:   state_d = S_FETCH;
            S_ADDR:   state_d = (bus.opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (cnt_q == MEM_LAST) state_d = S_WB_LD;
            S_WB_LD:  state_d = S_FETCH;
            S_MEM_WR: state_d = S_FETCH;
            S_BR:     state_d = S_FETCH;
            S_JMP:    state_d = S_FETCH;
            S_MD_START: begin
                if (bus.funct == 6'h1A && bus.md_div0) begin
                    state_d = S_EXC1;
                    cause_d = 2'b10;
                end else begin
                    state_d = S_MD_WAIT;
                end
            end
            S_MD_WAIT: if (cnt_q == MD_LAST) state_d = S_FETCH;
            S_EXC1:    state_d = S_EXC_RD;
            S_EXC_RD:  if (cnt_q == MEM_LAST) state_d = S_EXC_LD;
            S_EXC_LD:  state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
        // No state loops on itself except while waiting, so any state change
        // is a fresh entry and restarts the count.
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    // Moore output decode.
    // Reset forces the r29 <= 227 write and silences everything else.
    always_comb begin
        bus.pc_w          = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.ab_write      = 1'b0;
        bus.alu_out_write = 1'b0;
        bus.epc_write     = 1'b0;
        bus.md_start      = 1'b0;
        bus.alu_src_a     = 2'b00;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 3'b000;
        bus.reg_dst       = 2'b00;
        bus.mem_to_reg    = 2'b00;
        bus.pc_source     = 2'b00;
        bus.iord          = 2'b00;
        if (reset) begin
            bus.reg_write  = 1'b1;
            bus.reg_dst    = 2'b10;
            bus.mem_to_reg = 2'b11;
        end else begin
            case (state_q)
                S_IR_LD: begin
                    bus.ir_write  = 1'b1;
                    bus.pc_w      = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.alu_op    = 3'b001;
                end
                S_DECODE: begin
                    bus.ab_write      = 1'b1;
                    bus.alu_out_write = 1'b1;
                    bus.alu_src_b     = 2'b11;
                    bus.alu_op        = 3'b001;
                end
                S_EX_R: begin
                    bus.alu_src_a     = 2'b01;
                    bus.alu_out_write = 1'b1;
                    case (bus.funct)
                        6'h20:   bus.alu_op = 3'b001;
                        6'h22:   bus.alu_op = 3'b010;
                        default: bus.alu_op = 3'b011;
                    endcase
                end
                S_WB_R: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 2'b01;
                end
                S_EX_I, S_ADDR: begin
                    bus.alu_src_a     = 2'b01;
                    bus.alu_src_b     = 2'b10;
                    bus.alu_op        = 3'b001;
                    bus.alu_out_write = 1'b1;
                end
                S_WB_I:   bus.reg_write = 1'b1;
                S_MEM_RD: bus.iord = 2'b01;
                S_WB_LD: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 2'b01;
                end
                S_MEM_WR: begin
                    bus.iord   = 2'b01;
                    bus.mem_wr = 1'b1;
                end
                S_BR: begin
                    bus.alu_src_a = 2'b01;
                    bus.alu_op    = 3'b010;
                    bus.pc_source = 2'b01;
                    bus.pc_w      = (bus.opcode == 6'h04) ? bus.eq : ~bus.eq;
                end
                S_JMP: begin
                    bus.pc_source = 2'b10;
                    bus.pc_w      = 1'b1;
                end
                S_MD_START: bus.md_start = 1'b1;
                S_EXC1: begin
                    bus.epc_write = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.alu_op    = 3'b010;
                    bus.iord      = 2'b10;
                end
                S_EXC_RD: bus.iord = 2'b10;
                S_EXC_LD: begin
                    bus.pc_w      = 1'b1;
                    bus.pc_source = 2'b11;
                end
                default: ;
            endcase
        end
        bus.exc_cause = reset ? 2'b00 : cause_q;
        bus.state_dbg = reset ? 5'd0 : state_q;
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;
  localparam int MEM_WAIT  = 3;
  localparam int MD_CYCLES = 4;
  localparam int W         = 25;

  typedef struct packed {
    logic       pc_w;
    logic       mem_wr;
    logic       ir_write;
    logic       reg_write;
    logic       ab_write;
    logic       alu_out_write;
    logic       epc_write;
    logic       md_start;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] iord;
    logic [1:0] exc_cause;
  } ctl_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_control_fsm_if bus();

  mc_control_fsm #(.MEM_WAIT(MEM_WAIT), .MD_CYCLES(MD_CYCLES)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  ctl_t obs;
  assign obs = {bus.pc_w, bus.mem_wr, bus.ir_write, bus.reg_write, bus.ab_write,
                bus.alu_out_write, bus.epc_write, bus.md_start, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.reg_dst, bus.mem_to_reg,
                bus.pc_source, bus.iord, bus.exc_cause};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [1:0]   m_cause = 2'b00;
  int           n_checks = 0;
  int           n_pass = 0;

  // ---------------- reference model ----------------
  // Builds the expected per-cycle control word trace of one instruction
  // from its class.
  function automatic ctl_t quiet();
    ctl_t c = '0;
    c.exc_cause = m_cause;
    return c;
  endfunction

  function automatic ctl_t reset_word();
    ctl_t c = '0;
    c.reg_write  = 1'b1;
    c.reg_dst    = 2'b10;
    c.mem_to_reg = 2'b11;
    return c;
  endfunction

  task automatic model_exc(input logic [1:0] cause);
    ctl_t c;
    m_cause = cause;
    c = quiet(); c.epc_write = 1'b1; c.src_b = 2'b01; c.alu_op = 3'b010; c.iord = 2'b10;
    exp_q.push_back(c);
    repeat (MEM_WAIT) begin c = quiet(); c.iord = 2'b10; exp_q.push_back(c); end
    c = quiet(); c.pc_w = 1'b1; c.pc_source = 2'b11;
    exp_q.push_back(c);
  endtask

  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic of, input logic eq, input logic d0);
    ctl_t c;
    bit is_alu_r = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
    bit is_md    = (op == 6'h00) && (fn == 6'h18 || fn == 6'h1A);
    repeat (MEM_WAIT) exp_q.push_back(quiet());
    c = quiet(); c.ir_write = 1'b1; c.pc_w = 1'b1; c.src_b = 2'b01; c.alu_op = 3'b001;
    exp_q.push_back(c);
    c = quiet(); c.ab_write = 1'b1; c.alu_out_write = 1'b1; c.src_b = 2'b11; c.alu_op = 3'b001;
    exp_q.push_back(c);
    if (is_alu_r) begin
      c = quiet(); c.src_a = 2'b01; c.alu_out_write = 1'b1;
      c.alu_op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
      exp_q.push_back(c);
      if (of && fn != 6'h24) model_exc(2'b01);
      else begin c = quiet(); c.reg_write = 1'b1; c.reg_dst = 2'b01; exp_q.push_back(c); end
    end else if (is_md) begin
      c = quiet(); c.md_start = 1'b1; exp_q.push_back(c);
      if (fn == 6'h1A && d0) model_exc(2'b10);
      else repeat (MD_CYCLES) exp_q.push_back(quiet());
    end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
      c = quiet(); c.src_a = 2'b01; c.src_b = 2'b10; c.alu_op = 3'b001; c.alu_out_write = 1'b1;
      exp_q.push_back(c);
      if (op == 6'h08) begin
        if (of) model_exc(2'b01);
        else begin c = quiet(); c.reg_write = 1'b1; exp_q.push_back(c); end
      end else if (op == 6'h23) begin
        repeat (MEM_WAIT) begin c = quiet(); c.iord = 2'b01; exp_q.push_back(c); end
        c = quiet(); c.reg_write = 1'b1; c.mem_to_reg = 2'b01; exp_q.push_back(c);
      end else begin
        c = quiet(); c.iord = 2'b01; c.mem_wr = 1'b1; exp_q.push_back(c);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      c = quiet(); c.src_a = 2'b01; c.alu_op = 3'b010; c.pc_source = 2'b01;
      c.pc_w = (op == 6'h04) ? eq : !eq;
      exp_q.push_back(c);
    end else if (op == 6'h02) begin
      c = quiet(); c.pc_source = 2'b10; c.pc_w = 1'b1; exp_q.push_back(c);
    end else begin
      model_exc(2'b00);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction fields stay stable for the whole instruction (IR is loaded).
  task automatic drive_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic of, input logic eq, input logic d0);
    bus.opcode  = op;
    bus.funct   = fn;
    bus.of      = of;
    bus.eq      = eq;
    bus.md_div0 = d0;
    model_instr(op, fn, of, eq, d0);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) begin
      step();
      n_checks++;
      if (obs !== reset_word() || bus.state_dbg !== 5'd0)
        $display("FAIL reset_hold: got %h/%0d expected %h/0", obs, bus.state_dbg, reset_word());
      else n_pass++;
    end
    reset = 1'b0;
    m_cause = 2'b00;
    #1;
    n_checks++;
    if (obs !== quiet()) $display("FAIL reset_release_fetch: got %h expected %h", obs, quiet());
    else n_pass++;
  endtask

  task automatic test_add();
    ctl_t e;
    int wb_cyc = -1;
    drive_instr(6'h00, 6'h20, 1'b0, 1'b0, 1'b0);
    for (int i = 1; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (obs.reg_write) wb_cyc = i;
      n_checks++;
      if (obs !== e) $display("FAIL add_trace cyc%0d: got %h expected %h", i, obs, e);
      else n_pass++;
      step();
    end
    n_checks++;
    if (wb_cyc !== 7) $display("FAIL add_wb_cycle: got %0d expected 7", wb_cyc);
    else n_pass++;
    drive_instr(6'h00, 6'h20, 1'b1, 1'b0, 1'b0);
    for (int i = 1; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL add_of_trace cyc%0d: got %h expected %h", i, obs, e);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_md();
    ctl_t e;
    logic [5:0] fns[3] = '{6'h1A, 6'h1A, 6'h18};
    logic       d0s[3] = '{1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      drive_instr(6'h00, fns[k], 1'b0, 1'b0, d0s[k]);
      for (int i = 1; exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL md%0d_trace cyc%0d: got %h expected %h", k, i, obs, e);
        else n_pass++;
        step();
      end
    end
  endtask

  task automatic test_branch_jump_bad();
    ctl_t e;
    logic [5:0] ops[5] = '{6'h04, 6'h05, 6'h04, 6'h02, 6'h3F};
    logic       eqs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      drive_instr(ops[k], 6'h00, 1'b0, eqs[k], 1'b0);
      for (int i = 1; exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL ctl%0d_op%h_trace cyc%0d: got %h expected %h", k, ops[k], i, obs, e);
        else n_pass++;
        step();
      end
    end
  endtask

  task automatic test_mem();
    ctl_t e;
    logic [5:0] ops[3] = '{6'h23, 6'h2B, 6'h08};
    for (int k = 0; k < 3; k++) begin
      drive_instr(ops[k], 6'h00, 1'b0, 1'b0, 1'b0);
      for (int i = 1; exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL mem_op%h_trace cyc%0d: got %h expected %h", ops[k], i, obs, e);
        else n_pass++;
        step();
      end
    end
  endtask

  task automatic test_reset_mid_md();
    ctl_t e;
    drive_instr(6'h00, 6'h1A, 1'b0, 1'b0, 1'b0);
    // FETCH x MEM_WAIT, IR_LD, DECODE, MD_START, MD_WAIT 1, MD_WAIT 2
    for (int i = 1; i <= MEM_WAIT + 5; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL mdrst_pre cyc%0d: got %h expected %h", i, obs, e);
      else n_pass++;
      if (i < MEM_WAIT + 5) step();
    end
    exp_q.delete();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs !== reset_word() || bus.md_start !== 1'b0)
        $display("FAIL mdrst_hold%0d: got %h expected %h", i, obs, reset_word());
      else n_pass++;
      step();
    end
    reset = 1'b0;
    m_cause = 2'b00;
    #1;
    drive_instr(6'h00, 6'h1A, 1'b0, 1'b0, 1'b0);
    for (int i = 1; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL mdrst_post cyc%0d: got %h expected %h", i, obs, e);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_random();
    ctl_t e;
    logic [5:0] op, fn;
    logic [5:0] fn_tab[6] = '{6'h20, 6'h22, 6'h24, 6'h18, 6'h1A, 6'h00};
    logic [5:0] op_tab[7] = '{6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h00};
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: begin op = 6'h00; fn = fn_tab[$urandom_range(0, 5)]; end
        1: begin op = op_tab[$urandom_range(0, 6)]; fn = 6'($urandom_range(0, 63)); end
        default: begin op = 6'($urandom_range(0, 63)); fn = 6'($urandom_range(0, 63)); end
      endcase
      if (op == 6'h00 && $urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
      drive_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      for (int i = 1; exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e)
          $display("FAIL rand%0d_op%h_fn%h cyc%0d: got %h expected %h", n, op, fn, i, obs, e);
        else n_pass++;
        step();
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.opcode  = 6'h00;
    bus.funct   = 6'h00;
    bus.of      = 1'b0;
    bus.eq      = 1'b0;
    bus.md_div0 = 1'b0;
    test_reset();
    test_add();
    test_md();
    test_branch_jump_bad();
    test_mem();
    test_reset_mid_md();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
